ro_pair_comparator: RTL and testbench
=====================================

# ro_pair_comparator

Downstream consumer of the ROPUF challenge shift register. Each round it latches the 8-bit RO-pair selection, counts rising edges of the two selected ring oscillators over a fixed clock window, and compares the counts to produce one response bit. Sixteen rounds are shifted into a 16-bit PUF response word for the key generator. It also exports the round index that drives the shift register's `round` input.

## Interface

**Parameters**

- `NUM_RO`, 16: number of ring-oscillator inputs. The select fields are log2(`NUM_RO`) = 4 bits.
- `CNT_W`, 16: edge-counter width.
- `WINDOW`, 200: length of the COUNT state in clk cycles; must be ≥ 1.
- `ROUNDS`, 16: response bits per run; equals the response width.

**Ports** (one clock; reset is synchronous and active-high)

- `clk` input 1: system clock.
- `Reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle run request; honoured only in IDLE or DONE.
- `sel` input 8: RO-pair selection from the shift register. `sel[7:4]` = index A, `sel[3:0]` = index B.
- `ro_in` input `NUM_RO`: raw RO outputs, asynchronous to `clk`.
- `round` output 4: current round index, 0..`ROUNDS`-1.
- `busy` output 1: high in CLEAR, COUNT and COMPARE.
- `resp_valid` output 1: one-cycle pulse per completed round.
- `resp_bit` output 1: response bit for the current round; valid with `resp_valid`.
- `response` output `ROUNDS`: accumulated response word.
- `done` output 1: high while in DONE.

## Operation

**States:** IDLE, CLEAR, COUNT, COMPARE, DONE. Registered outputs are derived from state.

**Reset** (`Reset` high at a clk edge, from any state, including mid-count):
- state goes to IDLE.
- `round`, `response`, `resp_bit`, `resp_valid`, `busy`, `done`, both counters, the window timer and the synchronizers all clear to 0.

**IDLE**
- `start` = 1 → CLEAR.
- `round` and `response` are cleared on this transition.

**CLEAR** (1 cycle)
- Latch `sel` into `sel_q`.
- Zero both edge counters and the window timer.
- → COUNT.

**COUNT** (exactly `WINDOW` cycles)
- Each counter increments on a rising edge of its selected RO after the 2-flop synchronizer.
- Counters saturate at 2^`CNT_W`-1 and do not wrap.
- The selected RO's period must exceed 2 clk cycles for an exact count; this is a system requirement, not checked by the block.

**COMPARE** (1 cycle)
- `resp_bit` = (cntA > cntB). A tie gives 0, which includes the A == B selection case.
- `resp_valid` = 1.
- `response` = {`response`[`ROUNDS`-2:0], `resp_bit`}, so the first bit ends at the MSB.
- If `round` == `ROUNDS`-1 → DONE, with `round` held. Otherwise increment `round` → CLEAR.

**DONE**
- `done` = 1; `response` is held.
- `start` → CLEAR, with `round` and `response` cleared.

**Other rules**
- `start` in CLEAR, COUNT or COMPARE is ignored.
- `sel` changes outside CLEAR have no effect.
- The upstream shift register updates `sel` from `round`, and is sampled in the next CLEAR.

## Timing

- `start` sampled at edge T0 → CLEAR during cycle T0+1. COUNT runs T0+2 .. T0+1+`WINDOW`. COMPARE runs at T0+2+`WINDOW`.
- `resp_valid` is therefore high during cycle T0+2+`WINDOW`.
- Round period: `WINDOW`+2 cycles.
- `done` rises `ROUNDS`×(`WINDOW`+2)+1 cycles after T0. With defaults that is 3233.
- `busy` rises the cycle after `start` and falls as `done` rises.
- `round` changes on the edge that ends COMPARE.
- Synchronizer latency: 2 cycles plus 1 cycle for edge detect. RO edges arriving in the last 3 cycles of COUNT are not counted; this is accepted.

## Structure

**Shared package `ropuf_pkg`:**
- state enum (IDLE, CLEAR, COUNT, COMPARE, DONE);
- constants `RO_IDX_W`=4, `SEL_W`=8, `ROUNDS`=16, `CNT_W`=16;
- `sel` field positions.

**Sub-module `ro_edge_counter`** (instantiated twice):
- 16:1 mux on `ro_in` by index;
- 2-flop synchronizer;
- rising-edge detect;
- saturating `CNT_W` counter with synchronous clear and enable.

The top holds the FSM, window timer, round counter and response shifter.

## Test plan

- **Basic round:** `WINDOW`=200, RO5 period 4 clk, RO9 period 6 clk, `sel`=0x59, `start` → at T0+202 `resp_valid`=1, `resp_bit`=1, counts ≈50 vs ≈33.
- **Full run:** 16 rounds with RO A always faster on even rounds and slower on odd rounds → `response`=0xAAAA, `done` at T0+3233, `round`=15.
- **Tie and equal select:** `sel`=0x33 → `resp_bit`=0 every round. Counter saturation with `CNT_W`=4, `WINDOW`=200 → both counters at 15, `resp_bit`=0.
- **Reset mid-count:** `Reset` asserted in round 7, cycle 100 of COUNT → next cycle IDLE with all outputs 0. A fresh `start` produces round 0 timing identical to the basic-round scenario.
- **Start and select handling:** `start` pulses during COUNT are ignored, with period unchanged. `sel` changed mid-COUNT → no effect until the next CLEAR. `start` in DONE clears `response` to 0 and restarts at `round`=0.

Source files
------------

// File: rtl/ro_pair_comparator_pkg.sv
// ----------------------------------------------------------------------------
// ropuf_pkg
// Shared definitions for the ROPUF RO-pair comparator slice: FSM state
// encoding, default widths, and the bit positions of the two RO index fields
// inside the 8-bit pair selection word.
// ----------------------------------------------------------------------------
package ropuf_pkg;

    // Width of one ring-oscillator index (16 ROs)
    localparam int RO_IDX_W = 4;
    // Width of the pair selection word coming from the challenge shift register
    localparam int SEL_W    = 8;
    // Response bits per run; also the width of the response word
    localparam int ROUNDS   = 16;
    // Default edge-counter width
    localparam int CNT_W    = 16;

    // Field positions inside sel: upper nibble selects RO A, lower nibble RO B
    localparam int SEL_A_MSB = 7;
    localparam int SEL_A_LSB = 4;
    localparam int SEL_B_MSB = 3;
    localparam int SEL_B_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    // Extract the RO A index from a selection word
    function automatic logic [RO_IDX_W-1:0] sel_idx_a(input logic [SEL_W-1:0] s);
        return s[SEL_A_MSB:SEL_A_LSB];
    endfunction

    // Extract the RO B index from a selection word
    function automatic logic [RO_IDX_W-1:0] sel_idx_b(input logic [SEL_W-1:0] s);
        return s[SEL_B_MSB:SEL_B_LSB];
    endfunction

endpackage

// File: rtl/ro_pair_comparator_if.sv
// ----------------------------------------------------------------------------
// ro_pair_comparator_if
// Control/status bundle between the RO pair comparator and its neighbours
// (challenge shift register upstream, key generator downstream).
//   start      : one-cycle run request
//   sel        : RO pair selection, sel[7:4] = index A, sel[3:0] = index B
//   round      : current round index, drives the shift register
//   busy       : run in progress (CLEAR/COUNT/COMPARE)
//   resp_valid : one-cycle pulse per completed round
//   resp_bit   : response bit of the round just compared
//   response   : accumulated response word, first bit at the MSB
//   done       : run finished, response stable
// master = the side that requests runs, slave = the comparator.
// ----------------------------------------------------------------------------
interface ro_pair_comparator_if #(
    parameter int ROUNDS = ropuf_pkg::ROUNDS
) ();
    import ropuf_pkg::*;

    logic                start;
    logic [SEL_W-1:0]    sel;
    logic [RO_IDX_W-1:0] round;
    logic                busy;
    logic                resp_valid;
    logic                resp_bit;
    logic [ROUNDS-1:0]   response;
    logic                done;

    modport master (
        output start,
        output sel,
        input  round,
        input  busy,
        input  resp_valid,
        input  resp_bit,
        input  response,
        input  done
    );

    modport slave (
        input  start,
        input  sel,
        output round,
        output busy,
        output resp_valid,
        output resp_bit,
        output response,
        output done
    );

endinterface

// File: rtl/ro_pair_comparator_edge_counter.sv
// ----------------------------------------------------------------------------
// ro_edge_counter
// Counts rising edges of one selected ring oscillator.
// Ports:
//   clk, Reset : system clock, synchronous active-high reset
//   ro_in      : raw RO outputs, asynchronous to clk
//   idx        : which RO to count
//   clr        : synchronous clear of the count and of the flush guard
//   en         : count enable (COUNT window)
//   count      : saturating edge count
// ----------------------------------------------------------------------------
module ro_edge_counter #(
    parameter int NUM_RO = 16,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              Reset,
    input  logic [NUM_RO-1:0]                 ro_in,
    input  logic [ropuf_pkg::RO_IDX_W-1:0]    idx,
    input  logic                              clr,
    input  logic                              en,
    output logic [CNT_W-1:0]                  count
);
    import ropuf_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       ro_sel;
    logic       sync1;
    logic       sync2;
    logic       sync_prev;
    logic       rise;
    logic [2:0] flush;

    assign ro_sel = ro_in[idx];
    assign rise   = sync2 & ~sync_prev;

    // Two-flop synchronizer on the muxed RO, plus one more stage so a rising
    // edge can be detected entirely in the clk domain.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= ro_sel;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // The index changes at the end of CLEAR, so the three pipeline stages still
    // hold samples of the previously selected RO for a few cycles. This guard
    // fills with ones after a clear and edges are only counted once every
    // stage holds the new RO, which keeps old-RO history from faking an edge.
    always_ff @(posedge clk) begin
        if (Reset || clr) begin
            flush <= 3'b000;
        end else begin
            flush <= {flush[1:0], 1'b1};
        end
    end

    // Saturating counter: sticks at all-ones instead of wrapping so a very
    // fast RO can never appear slower than a slow one.
    always_ff @(posedge clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (en && flush[2] && rise && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_pair_comparator.sv
// ----------------------------------------------------------------------------
// ro_pair_comparator
// Runs ROUNDS comparison rounds. Each round latches an RO pair selection,
// counts edges of both ROs for WINDOW clk cycles, and shifts (countA > countB)
// into the response word. The round index is exported so the upstream
// challenge shift register can present the next selection.
// Ports:
//   clk, Reset : system clock, synchronous active-high reset
//   ro_in      : raw RO outputs, asynchronous to clk
//   bus        : ro_pair_comparator_if.slave (start/sel in, status/response out)
// ----------------------------------------------------------------------------
module ro_pair_comparator #(
    parameter int NUM_RO = 16,
    parameter int CNT_W  = ropuf_pkg::CNT_W,
    parameter int WINDOW = 200,
    parameter int ROUNDS = ropuf_pkg::ROUNDS
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [NUM_RO-1:0]   ro_in,
    ro_pair_comparator_if.slave bus
);
    import ropuf_pkg::*;

    localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(WINDOW - 1);
    localparam logic [RO_IDX_W-1:0] ROUND_LAST = RO_IDX_W'(ROUNDS - 1);

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic [TMR_W-1:0]    timer;
    logic [RO_IDX_W-1:0] round_q;
    logic [ROUNDS-1:0]   response_q;
    logic                resp_bit_q;
    logic                resp_valid_q;
    logic                busy_q;
    logic                done_q;

    logic [CNT_W-1:0]    cnt_a;
    logic [CNT_W-1:0]    cnt_b;
    logic                cnt_clr;
    logic                cnt_en;
    logic                a_wins;

    assign cnt_clr = (state == CLEAR);
    assign cnt_en  = (state == COUNT);
    assign a_wins  = (cnt_a > cnt_b);

    ro_edge_counter #(
        .NUM_RO (NUM_RO),
        .CNT_W  (CNT_W)
    ) u_cnt_a (
        .clk   (clk),
        .Reset (Reset),
        .ro_in (ro_in),
        .idx   (sel_idx_a(sel_q)),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_a)
    );

    ro_edge_counter #(
        .NUM_RO (NUM_RO),
        .CNT_W  (CNT_W)
    ) u_cnt_b (
        .clk   (clk),
        .Reset (Reset),
        .ro_in (ro_in),
        .idx   (sel_idx_b(sel_q)),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_b)
    );

    // Round sequencer. Every status output is registered here alongside the
    // state so each one lines up exactly with the state it describes.
    // The compare result is captured on the edge that leaves COUNT, so it and
    // resp_valid appear together during the COMPARE cycle; an edge landing in
    // the final COUNT cycle is not part of the result.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= IDLE;
            sel_q        <= '0;
            timer        <= '0;
            round_q      <= '0;
            response_q   <= '0;
            resp_bit_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= CLEAR;
                        round_q    <= '0;
                        response_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    sel_q <= bus.sel;
                    timer <= '0;
                    state <= COUNT;
                end
                COUNT: begin
                    if (timer == TMR_LAST) begin
                        state        <= COMPARE;
                        resp_bit_q   <= a_wins;
                        resp_valid_q <= 1'b1;
                        response_q   <= {response_q[ROUNDS-2:0], a_wins};
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                COMPARE: begin
                    if (round_q == ROUND_LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        round_q <= round_q + RO_IDX_W'(1);
                        state   <= CLEAR;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state      <= CLEAR;
                        round_q    <= '0;
                        response_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.round      = round_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_bit   = resp_bit_q;
    assign bus.response   = response_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_ro_pair_comparator.sv
// ----------------------------------------------------------------------------
// tb_ro_pair_comparator
// Directed bench for ro_pair_comparator. A main instance (CNT_W=16) and a
// saturation instance (CNT_W=4) share the modelled RO outputs. RO5 runs with
// a 4-clk period, RO9 with 6 clk, RO3 with 5 clk; all other ROs are idle.
// ----------------------------------------------------------------------------
module tb_ro_pair_comparator;
    import ropuf_pkg::*;

    localparam int W         = 200;
    localparam int RUN_EDGES = 16 * (W + 2);

    logic        clk;
    logic        Reset;
    logic [15:0] ro_in;

    int          ro_half  [16];
    int          ro_phase [16];
    int          edges;
    int          checks;
    int          fails;
    logic [15:0] resp_exp;
    logic        exp_bit;

    ro_pair_comparator_if bus ();
    ro_pair_comparator_if sat_bus ();

    ro_pair_comparator #(
        .NUM_RO (16),
        .CNT_W  (16),
        .WINDOW (W),
        .ROUNDS (16)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .ro_in (ro_in),
        .bus   (bus)
    );

    ro_pair_comparator #(
        .NUM_RO (16),
        .CNT_W  (4),
        .WINDOW (W),
        .ROUNDS (16)
    ) dut_sat (
        .clk   (clk),
        .Reset (Reset),
        .ro_in (ro_in),
        .bus   (sat_bus)
    );

    // Clock: 20 time units per period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // RO model: 10 ticks per clk period, ticks at odd times so no RO edge ever
    // coincides with a clk edge. ro_half is the half period in ticks.
    initial begin
        ro_in = '0;
        for (int i = 0; i < 16; i++) ro_phase[i] = 0;
        #1;
        forever begin
            #2;
            for (int i = 0; i < 16; i++) begin
                if (ro_half[i] > 0) begin
                    ro_phase[i]++;
                    if (ro_phase[i] >= ro_half[i]) begin
                        ro_phase[i] = 0;
                        ro_in[i]    = ~ro_in[i];
                    end
                end
            end
        end
    end

    // Advance n clk edges and settle 1 unit past the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    // Advance to the given edge index counted from the start edge (edge 0)
    task automatic advance_to(input int target);
        if (target > edges) step(target - edges);
    endtask

    // Edge after which resp_valid of round r is visible
    function automatic int rv_edge(input int r);
        return (W + 1) + r * (W + 2);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on the main instance; the sampling edge becomes edge 0
    task automatic apply_stimulus_start();
        bus.start = 1'b1;
        edges     = -1;
        step(1);
        bus.start = 1'b0;
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        edges         = 0;
        Reset         = 1'b1;
        bus.start     = 1'b0;
        bus.sel       = 8'h59;
        sat_bus.start = 1'b0;
        sat_bus.sel   = 8'h59;
        for (int i = 0; i < 16; i++) ro_half[i] = 0;
        ro_half[5] = 20;
        ro_half[9] = 30;
        ro_half[3] = 25;

        $display("[TB] reset state");
        step(3);
        check_output("rst_round",      32'(bus.round),      32'h0);
        check_output("rst_busy",       32'(bus.busy),       32'h0);
        check_output("rst_done",       32'(bus.done),       32'h0);
        check_output("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check_output("rst_resp_bit",   32'(bus.resp_bit),   32'h0);
        check_output("rst_response",   32'(bus.response),   32'h0);
        Reset = 1'b0;
        step(2);
        check_output("idle_busy", 32'(bus.busy), 32'h0);

        $display("[TB] basic round and full 16-round run");
        sat_bus.start = 1'b1;
        apply_stimulus_start();
        sat_bus.start = 1'b0;
        check_output("start_busy",     32'(bus.busy),     32'h1);
        check_output("start_round",    32'(bus.round),    32'h0);
        check_output("sat_start_busy", 32'(sat_bus.busy), 32'h1);
        resp_exp = '0;
        for (int r = 0; r < 16; r++) begin
            if (r == 2) begin
                advance_to(rv_edge(r) - 100);
                bus.sel = 8'h95;
            end
            if (r == 4) begin
                advance_to(rv_edge(r) - 100);
                bus.start = 1'b1;
                step(1);
                bus.start = 1'b0;
            end
            if (r == 0) begin
                advance_to(rv_edge(0) - 1);
                check_output("r0_pre_valid", 32'(bus.resp_valid), 32'h0);
            end
            advance_to(rv_edge(r));
            exp_bit  = ((r % 2) == 0);
            resp_exp = {resp_exp[14:0], exp_bit};
            check_output($sformatf("r%0d_valid", r),    32'(bus.resp_valid), 32'h1);
            check_output($sformatf("r%0d_bit", r),      32'(bus.resp_bit),   32'(exp_bit));
            check_output($sformatf("r%0d_response", r), 32'(bus.response),   32'(resp_exp));
            check_output($sformatf("r%0d_round", r),    32'(bus.round),      32'(r));
            if (r == 0) begin
                check_output("sat_r0_valid", 32'(sat_bus.resp_valid), 32'h1);
                check_output("sat_r0_bit",   32'(sat_bus.resp_bit),   32'h0);
            end
            bus.sel = ((r % 2) == 0) ? 8'h95 : 8'h59;
            if (r == 0) begin
                step(1);
                check_output("r0_post_valid", 32'(bus.resp_valid), 32'h0);
                check_output("r0_post_round", 32'(bus.round),      32'h1);
            end
        end
        advance_to(RUN_EDGES - 1);
        check_output("pre_done",      32'(bus.done),     32'h0);
        check_output("pre_done_busy", 32'(bus.busy),     32'h1);
        advance_to(RUN_EDGES);
        check_output("done",          32'(bus.done),     32'h1);
        check_output("done_busy",     32'(bus.busy),     32'h0);
        check_output("done_round",    32'(bus.round),    32'hF);
        check_output("done_response", 32'(bus.response), 32'hAAAA);
        step(5);
        check_output("done_hold",     32'(bus.done),     32'h1);
        check_output("done_hold_rsp", 32'(bus.response), 32'hAAAA);

        $display("[TB] restart from DONE, tie select, reset mid-count");
        bus.sel = 8'h33;
        apply_stimulus_start();
        check_output("restart_response", 32'(bus.response), 32'h0);
        check_output("restart_round",    32'(bus.round),    32'h0);
        check_output("restart_done",     32'(bus.done),     32'h0);
        check_output("restart_busy",     32'(bus.busy),     32'h1);
        resp_exp = '0;
        for (int r = 0; r < 7; r++) begin
            advance_to(rv_edge(r));
            exp_bit  = (r >= 3);
            resp_exp = {resp_exp[14:0], exp_bit};
            check_output($sformatf("t%0d_bit", r),      32'(bus.resp_bit), 32'(exp_bit));
            check_output($sformatf("t%0d_response", r), 32'(bus.response), 32'(resp_exp));
            bus.sel = ((r + 1) >= 3) ? 8'h59 : 8'h33;
        end
        advance_to(rv_edge(7) - 100);
        Reset = 1'b1;
        step(1);
        check_output("mid_rst_round",      32'(bus.round),      32'h0);
        check_output("mid_rst_response",   32'(bus.response),   32'h0);
        check_output("mid_rst_busy",       32'(bus.busy),       32'h0);
        check_output("mid_rst_done",       32'(bus.done),       32'h0);
        check_output("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check_output("mid_rst_resp_bit",   32'(bus.resp_bit),   32'h0);
        Reset = 1'b0;
        step(2);
        check_output("post_rst_idle_busy", 32'(bus.busy), 32'h0);

        $display("[TB] fresh start after reset");
        bus.sel = 8'h59;
        apply_stimulus_start();
        advance_to(W);
        check_output("fresh_pre_valid", 32'(bus.resp_valid), 32'h0);
        advance_to(W + 1);
        check_output("fresh_valid",    32'(bus.resp_valid), 32'h1);
        check_output("fresh_bit",      32'(bus.resp_bit),   32'h1);
        check_output("fresh_response", 32'(bus.response),   32'h1);
        check_output("fresh_round",    32'(bus.round),      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
